// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and defaults for the round-robin gcd scheduler
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } gcd_sched_state_t;

  localparam int GCD_W = 8;

endpackage

// File: rtl/gcd_rr_scheduler_if.sv
// rtl/gcd_rr_scheduler_if.sv - start/ready handshake between scheduler and shared gcd engine
interface gcd_rr_scheduler_if
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
);

  logic         core_start;
  logic [W-1:0] core_ina;
  logic [W-1:0] core_inb;
  logic         core_ready;
  logic [W-1:0] core_out;

  modport master (
    output core_start,
    output core_ina,
    output core_inb,
    input  core_ready,
    input  core_out
  );

  modport slave (
    input  core_start,
    input  core_ina,
    input  core_inb,
    output core_ready,
    output core_out
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last served requester
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan last+1, last+2, ... with wrap; first set request wins
  always_comb begin
    int p;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    p     = 0;
    for (int k = 1; k <= N; k++) begin
      p = (int'(last) + k) % N;
      if (!any && req[p]) begin
        any      = 1'b1;
        grant[p] = 1'b1;
        idx      = IW'(p);
      end
    end
  end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// rtl/gcd_rr_scheduler.sv - shares one gcd engine between N requesters; optional GCD_EQ_BYPASS_EN skips the engine for a==b
module gcd_rr_scheduler
  import gcd_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = GCD_W,
  parameter int IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [N-1:0]        req,
  input  logic [N*W-1:0]      req_a,
  input  logic [N*W-1:0]      req_b,
  output logic [N-1:0]        ack,
  output logic [W-1:0]        res,
  output logic                busy,
  output logic [IW-1:0]       grant_id,
  gcd_rr_scheduler_if.master  core
);

  gcd_sched_state_t state;
  logic [IW-1:0]    last;
  logic [N-1:0]     gnt_q;
  logic             guard;
  logic             start_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;

  logic [N-1:0]     grant;
  logic [IW-1:0]    idx;
  logic             any;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req   (req),
    .last  (last),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign sel_a = req_a[int'(idx)*W +: W];
  assign sel_b = req_b[int'(idx)*W +: W];

  assign core.core_start = start_q;
  assign core.core_ina   = a_q;
  assign core.core_inb   = b_q;

  // scheduler FSM: grant, optional bypass, one-cycle start, wait for engine, one-cycle ack
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      ack      <= '0;
      res      <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      gnt_q    <= '0;
      guard    <= 1'b0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      last     <= IW'(N-1);
    end else begin
      ack     <= '0;
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any && core.core_ready) begin
            grant_id <= idx;
            gnt_q    <= grant;
            a_q      <= sel_a;
            b_q      <= sel_b;
            busy     <= 1'b1;
            // zero operands would never terminate in the engine
            if (sel_a == '0 || sel_b == '0) begin
              res   <= sel_a | sel_b;
              ack   <= grant;
              state <= RESP;
            end
`ifdef GCD_EQ_BYPASS_EN
            else if (sel_a == sel_b) begin
              res   <= sel_a;
              ack   <= grant;
              state <= RESP;
            end
`endif
            else begin
              start_q <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          guard <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          // engine's ready is stale in the first cycle after start
          if (guard) begin
            guard <= 1'b0;
          end else if (core.core_ready) begin
            res   <= core.core_out;
            ack   <= gnt_q;
            state <= RESP;
          end
        end
        RESP: begin
          last  <= grant_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// tb/tb_gcd_rr_scheduler.sv - scoreboard bench for gcd_rr_scheduler with a behavioural gcd engine
module tb_gcd_rr_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   res;
  logic           busy;
  logic [1:0]     grant_id;

  gcd_rr_scheduler_if #(.W(W)) core_if ();

  gcd_rr_scheduler #(.N(N), .W(W)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .req      (req),
    .req_a    (req_a),
    .req_b    (req_b),
    .ack      (ack),
    .res      (res),
    .busy     (busy),
    .grant_id (grant_id),
    .core     (core_if)
  );

  always #5 clk = ~clk;

  // subtractive gcd engine: drops ready on the edge that samples start
  logic [W-1:0] ex, ey;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      core_if.core_ready <= 1'b1;
      core_if.core_out   <= '0;
      ex <= '0;
      ey <= '0;
    end else if (core_if.core_ready && core_if.core_start) begin
      ex <= core_if.core_ina;
      ey <= core_if.core_inb;
      core_if.core_ready <= 1'b0;
    end else if (!core_if.core_ready) begin
      if (ex == ey) begin
        core_if.core_out   <= ex;
        core_if.core_ready <= 1'b1;
      end else if (ex > ey) begin
        ex <= ex - ey;
      end else begin
        ey <= ey - ex;
      end
    end
  end

  typedef struct {
    int           id;
    logic [W-1:0] val;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           acks_seen = 0;
  int           start_cnt = 0;
  logic [W-1:0] last_ina = '0;
  logic [W-1:0] last_inb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every ack and records engine starts
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (core_if.core_start) begin
          start_cnt++;
          last_ina = core_if.core_ina;
          last_inb = core_if.core_inb;
        end
        if (ack != '0) begin
          acks_seen++;
          if (sb.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("ack_onehot", 32'(ack), 32'd1 << e.id);
            chk("res", 32'(res), 32'(e.val));
            chk("grant_id", 32'(grant_id), 32'(e.id));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req  = '0;
    idle(2);
    nrst = 1'b1;
    idle(2);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r);
    exp_t e;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req[i] = 1'b1;
    e.id  = i;
    e.val = r;
    sb.push_back(e);
  endtask

  task automatic wait_acks(input int n, input bit hold);
    int target;
    bit done;
    target = acks_seen + n;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      #1;
      if (!hold) req = req & ~ack;
      if (acks_seen >= target) done = 1'b1;
    end
    if (!done) chk("ack_timeout", 32'(acks_seen), 32'(target));
    if (hold) req = '0;
  endtask

  initial begin
    int s0;
    exp_t e;
    bit seen;

    // reset state
    idle(1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(core_if.core_start), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    do_reset();

    // single requester through the engine
    s0 = start_cnt;
    set_req(1, 8'd48, 8'd18, 8'd6);
    wait_acks(1, 1'b0);
    chk("t1_start_pulses", 32'(start_cnt - s0), 32'd1);
    chk("t1_ina", 32'(last_ina), 32'd48);
    chk("t1_inb", 32'(last_inb), 32'd18);
    idle(2);

    // simultaneous requests from fresh pointer
    do_reset();
    set_req(0, 8'd12, 8'd8, 8'd4);
    set_req(2, 8'd9, 8'd6, 8'd3);
    wait_acks(2, 1'b0);
    idle(2);

    // zero-operand bypass
    s0 = start_cnt;
    set_req(3, 8'd0, 8'd35, 8'd35);
    @(negedge clk); #1;
    chk("t3_bypass_lat_a", 32'(ack), 32'b1000);
    req[3] = 1'b0;
    idle(2);
    set_req(3, 8'd0, 8'd0, 8'd0);
    @(negedge clk); #1;
    chk("t3_bypass_lat_b", 32'(ack), 32'b1000);
    req[3] = 1'b0;
    idle(2);
    chk("t3_no_start", 32'(start_cnt - s0), 32'd0);

    // all four held high: rotation 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, 8'd21, 8'd14, 8'd7);
    e.id = 0;
    e.val = 8'd7;
    sb.push_back(e);
    wait_acks(5, 1'b1);
    idle(2);
    chk("t4_sb_drained", 32'(sb.size()), 32'd0);

    // reset while waiting on the engine
    s0 = start_cnt;
    req_a[0 +: W] = 8'd255;
    req_b[0 +: W] = 8'd1;
    req[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk); #1;
      if (start_cnt > s0) seen = 1'b1;
    end
    chk("t5_start_seen", 32'(seen), 32'd1);
    idle(3);
    nrst = 1'b0;
    req = '0;
    #1;
    chk("t5_rst_ack", 32'(ack), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_start", 32'(core_if.core_start), 32'd0);
    idle(2);
    nrst = 1'b1;
    idle(2);
    set_req(0, 8'd10, 8'd4, 8'd2);
    set_req(3, 8'd5, 8'd0, 8'd5);
    wait_acks(2, 1'b0);
    idle(2);

    // equal operands
    s0 = start_cnt;
    set_req(1, 8'd7, 8'd7, 8'd7);
`ifdef GCD_EQ_BYPASS_EN
    @(negedge clk); #1;
    chk("t6_eq_bypass_lat", 32'(ack), 32'b0010);
    req[1] = 1'b0;
    idle(2);
    chk("t6_eq_no_start", 32'(start_cnt - s0), 32'd0);
`else
    wait_acks(1, 1'b0);
    idle(2);
    chk("t6_eq_start", 32'(start_cnt - s0), 32'd1);
`endif
    chk("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
